// File: rtl/fib_pkg.sv
// Shared types and BCD helpers for the Fibonacci BCD engine.
package fib_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 8;
  localparam int MAX_BCD_W  = BCD_W * MAX_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fib_state_t;

  // Only the low ndig digits of the zero-extended operand are examined.
  function automatic logic bcd_valid(input logic [MAX_BCD_W-1:0] bcd, input int ndig);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < ndig && bcd[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int unsigned bcd_to_bin(input logic [MAX_BCD_W-1:0] bcd, input int ndig);
    int unsigned acc;
    acc = 0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < ndig) acc = acc * 32'd10 + 32'(bcd[i*BCD_W +: BCD_W]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One BCD digit plus carry-in; combinational, no flow control.
module bcd_digit_adder
  import fib_pkg::*;
(
  input  logic [BCD_W-1:0] a_i,
  input  logic [BCD_W-1:0] b_i,
  input  logic             c_i,
  output logic [BCD_W-1:0] s_o,
  output logic             c_o
);

  logic [BCD_W:0] bin_sum;
  logic [BCD_W:0] adj_sum;

  always_comb begin
    bin_sum = {1'b0, a_i} + {1'b0, b_i} + {{BCD_W{1'b0}}, c_i};
    adj_sum = bin_sum + 5'd6;
    if (bin_sum > 5'd9) begin
      s_o = adj_sum[BCD_W-1:0];
      c_o = 1'b1;
    end else begin
      s_o = bin_sum[BCD_W-1:0];
      c_o = 1'b0;
    end
  end

endmodule

// File: rtl/fib_bcd_engine.sv
// Computes F(n) in BCD, one iteration per cycle: done n+1 cycles after accept (earlier on overflow).
// Start is only taken while ready_o is high; requests during RUN/DONE are dropped.
module fib_bcd_engine
  import fib_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int IN_DIGITS = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      start_i,
  input  logic [BCD_W*IN_DIGITS-1:0] n_bcd_i,
  output logic                      ready_o,
  output logic                      done_o,
  output logic [BCD_W*DIGITS-1:0]   result_bcd_o,
  output logic                      overflow_o,
  output logic                      error_o
);

  localparam int RW    = BCD_W * DIGITS;
  localparam int NW    = BCD_W * IN_DIGITS;
  localparam int CNT_W = $clog2(10 ** IN_DIGITS);

  fib_state_t        state_q, state_d;
  logic [RW-1:0]     a_q, a_d, b_q, b_d;
  logic              a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d, done_q, done_d;
  logic [RW-1:0]     result_q, result_d;
  logic              overflow_q, overflow_d, error_q, error_d;

  logic [MAX_BCD_W-1:0] n_ext;
  logic                 n_ok;
  logic [CNT_W-1:0]     n_bin;
  logic [RW-1:0]        sum;
  logic [RW-1:0]        nines;
  logic [DIGITS:0]      carry;

  always_comb begin
    n_ext          = '0;
    n_ext[NW-1:0]  = n_bcd_i;
    n_ok           = bcd_valid(n_ext, IN_DIGITS);
    n_bin          = CNT_W'(bcd_to_bin(n_ext, IN_DIGITS));
  end

  assign carry[0] = 1'b0;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adder u_add (
      .a_i (a_q[g*BCD_W +: BCD_W]),
      .b_i (b_q[g*BCD_W +: BCD_W]),
      .c_i (carry[g]),
      .s_o (sum[g*BCD_W +: BCD_W]),
      .c_o (carry[g+1])
    );
    assign nines[g*BCD_W +: BCD_W] = 4'd9;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    a_ovf_d    = a_ovf_q;
    b_ovf_d    = b_ovf_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    error_d    = error_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start_i) begin
          ready_d = 1'b0;
          if (!n_ok) begin
            state_d    = DONE;
            done_d     = 1'b1;
            result_d   = '0;
            overflow_d = 1'b0;
            error_d    = 1'b1;
          end else begin
            state_d = RUN;
            a_d     = '0;
            b_d     = RW'(1);
            a_ovf_d = 1'b0;
            b_ovf_d = 1'b0;
            cnt_d   = n_bin;
          end
        end
      end

      RUN: begin
        if (cnt_q == '0) begin
          state_d    = DONE;
          done_d     = 1'b1;
          result_d   = a_ovf_q ? nines : a_q;
          overflow_d = a_ovf_q;
          error_d    = 1'b0;
        end else begin
          a_d     = b_q;
          a_ovf_d = b_ovf_q;
          b_d     = sum;
          b_ovf_d = a_ovf_q | b_ovf_q | carry[DIGITS];
          cnt_d   = cnt_q - 1'b1;
          // The value moving into a is already past range: no later step can recover it.
          if (b_ovf_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            result_d   = nines;
            overflow_d = 1'b1;
            error_d    = 1'b0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      a_ovf_q    <= 1'b0;
      b_ovf_q    <= 1'b0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_ovf_q    <= a_ovf_d;
      b_ovf_q    <= b_ovf_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  assign ready_o      = ready_q;
  assign done_o       = done_q;
  assign result_bcd_o = result_q;
  assign overflow_o   = overflow_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_fib_bcd_engine.sv
// Bench for fib_bcd_engine at DIGITS=4 and DIGITS=6, checked against an integer Fibonacci model.
module tb_fib_bcd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        st4, st6;
  logic [7:0]  n4, n6;
  logic        rdy4, done4, ovf4, err4;
  logic        rdy6, done6, ovf6, err6;
  logic [15:0] res4;
  logic [23:0] res6;

  int checks   = 0;
  int failures = 0;

  fib_bcd_engine #(.DIGITS(4), .IN_DIGITS(2)) u_dut4 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(st4), .n_bcd_i(n4),
    .ready_o(rdy4), .done_o(done4), .result_bcd_o(res4),
    .overflow_o(ovf4), .error_o(err4)
  );

  fib_bcd_engine #(.DIGITS(6), .IN_DIGITS(2)) u_dut6 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(st6), .n_bcd_i(n6),
    .ready_o(rdy6), .done_o(done6), .result_bcd_o(res6),
    .overflow_o(ovf6), .error_o(err6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] res_of(input bit six);
    return six ? 32'(res6) : 32'(res4);
  endfunction
  function automatic logic done_of(input bit six);
    return six ? done6 : done4;
  endfunction
  function automatic logic rdy_of(input bit six);
    return six ? rdy6 : rdy4;
  endfunction
  function automatic logic ovf_of(input bit six);
    return six ? ovf6 : ovf4;
  endfunction
  function automatic logic err_of(input bit six);
    return six ? err6 : err4;
  endfunction

  task automatic drive(input bit six, input logic s, input logic [7:0] n);
    if (six) begin st6 = s; n6 = n; end
    else     begin st4 = s; n4 = n; end
  endtask

  // Reference: plain integer Fibonacci; lat = edges after the accepting edge until done is visible.
  function automatic void model(input int digits, input logic [7:0] n,
                                output logic [31:0] res, output bit ovf,
                                output bit err, output int lat);
    longint lim, a, b, t, v;
    int nv;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    res = '0; ovf = 0; err = 0;
    if (n[7:4] > 4'd9 || n[3:0] > 4'd9) begin
      err = 1; lat = 0;
      return;
    end
    nv = int'(n[7:4]) * 10 + int'(n[3:0]);
    lat = nv + 1;
    a = 0; b = 1;
    for (int i = 1; i <= nv; i++) begin
      t = a + b; a = b; b = t;
      if (a >= lim) begin ovf = 1; lat = i; break; end
    end
    v = ovf ? lim - 1 : a;
    for (int d = 0; d < digits; d++) begin
      res[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  task automatic run(input bit six, input logic [7:0] n, input bit poke);
    logic [31:0] e_res;
    bit e_ovf, e_err;
    int e_lat, cyc;
    model(six ? 6 : 4, n, e_res, e_ovf, e_err, e_lat);
    @(negedge clk);
    check($sformatf("ready_before n=%0h d%0d", n, six ? 6 : 4), 32'(rdy_of(six)), 32'd1);
    drive(six, 1'b1, n);
    @(posedge clk); #1;
    drive(six, 1'b0, n);
    cyc = 0;
    while (!done_of(six) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 3) drive(six, 1'b1, 8'h05);
      else                  drive(six, 1'b0, n);
    end
    drive(six, 1'b0, n);
    check($sformatf("latency n=%0h d%0d", n, six ? 6 : 4), 32'(cyc), 32'(e_lat));
    check($sformatf("result n=%0h d%0d", n, six ? 6 : 4), res_of(six), e_res);
    check($sformatf("overflow n=%0h d%0d", n, six ? 6 : 4), 32'(ovf_of(six)), 32'(e_ovf));
    check($sformatf("error n=%0h d%0d", n, six ? 6 : 4), 32'(err_of(six)), 32'(e_err));
    @(posedge clk); #1;
    check($sformatf("done_pulse n=%0h", n), 32'(done_of(six)), 32'd0);
    check($sformatf("ready_after n=%0h", n), 32'(rdy_of(six)), 32'd1);
    check($sformatf("result_hold n=%0h", n), res_of(six), e_res);
  endtask

  initial begin
    bit seen;
    logic [3:0] hi, lo;
    rst_n = 1'b0;
    st4 = 1'b0; st6 = 1'b0; n4 = '0; n6 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready4", 32'(rdy4), 32'd1);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_res4", 32'(res4), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready4", 32'(rdy4), 32'd1);
    check("post_rst_ready6", 32'(rdy6), 32'd1);
    check("post_rst_res6", 32'(res6), 32'd0);
    check("post_rst_flags", {30'd0, ovf4 | ovf6, err4 | err6}, 32'd0);

    run(0, 8'h00, 0);
    run(0, 8'h01, 0);
    run(0, 8'h10, 0);
    run(0, 8'h20, 0);
    run(0, 8'h21, 0);
    run(0, 8'h99, 0);
    run(0, 8'h1A, 0);
    run(0, 8'h10, 1);
    run(1, 8'h20, 0);
    run(1, 8'h30, 0);
    run(1, 8'h99, 0);

    // Reset in the middle of a long run: everything returns to reset values, no done.
    @(negedge clk);
    drive(0, 1'b1, 8'h50);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h50);
    repeat (10) @(posedge clk);
    #1;
    check("midrun_busy", 32'(rdy4), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_ready", 32'(rdy4), 32'd1);
    check("midrun_rst_res4", 32'(res4), 32'd0);
    check("midrun_rst_res6", 32'(res6), 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done4) seen = 1;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (done4) seen = 1;
    end
    check("midrun_no_done", 32'(seen), 32'd0);
    check("midrun_idle", 32'(rdy4), 32'd1);

    for (int r = 0; r < 24; r++) begin
      hi = 4'($urandom_range(0, 9));
      lo = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) lo = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 11) == 0) hi = 4'($urandom_range(10, 15));
      run(r[0], {hi, lo}, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
